// File: rtl/alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_ctrl
// Description : Bit-serial sequencer for a one-bit combinational ALU slice.
//               Accepts a word-wide operation on start (IDLE only), walks the
//               operands through the slice LSB first, one bit per clock, and
//               assembles the result word plus carry/overflow/zero flags.
// Ports       : clk, rst (async, active-high)
//               start, op[2:0], sub, a, b      - operation request
//               busy, done, result, carry, ovf, zero - status / result
//               slice_a/b/sub/cin/c1/c2/c3     - registered drive to slice
//               slice_out, slice_cout          - combinational slice returns
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_sub,
    output logic             slice_cin,
    output logic             slice_c1,
    output logic             slice_c2,
    output logic             slice_c3,
    input  logic             slice_out,
    input  logic             slice_cout
);

    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [2:0]         c_op_arith = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    // Operand shift registers hold the bits not yet presented to the slice;
    // bit 0 is always consumed directly from the port at accept time.
    logic [WIDTH-2:0]   a_q, a_d;
    logic [WIDTH-2:0]   b_q, b_d;
    // Collected result bits 0..WIDTH-2; the MSB arrives on the final edge.
    logic [WIDTH-2:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               slice_a_q, slice_a_d;
    logic               slice_b_q, slice_b_d;
    logic               slice_sub_q, slice_sub_d;
    // slice_cin_q doubles as the running carry register of the serial add.
    logic               slice_cin_q, slice_cin_d;
    logic [2:0]         slice_op_q, slice_op_d;
    logic [WIDTH-1:0]   w_final;
    logic               w_arith;

    assign w_arith = (slice_op_q == c_op_arith);
    assign w_final = {slice_out, sh_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        sh_d        = sh_q;
        result_d    = result_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        slice_a_d   = slice_a_q;
        slice_b_d   = slice_b_q;
        slice_sub_d = slice_sub_q;
        slice_cin_d = slice_cin_q;
        slice_op_d  = slice_op_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    cnt_d       = '0;
                    a_d         = a[WIDTH-1:1];
                    b_d         = b[WIDTH-1:1];
                    busy_d      = 1'b1;
                    slice_a_d   = a[0];
                    slice_b_d   = b[0];
                    slice_sub_d = sub;
                    slice_cin_d = sub;
                    slice_op_d  = op;
                end
            end
            ST_RUN: begin
                sh_d             = sh_q >> 1;
                sh_d[WIDTH-2]    = slice_out;
                a_d              = a_q >> 1;
                b_d              = b_q >> 1;
                slice_a_d        = a_q[0];
                slice_b_d        = b_q[0];
                slice_cin_d      = slice_cout;
                cnt_d            = cnt_q + 1'b1;
                if (cnt_q == c_last) begin
                    state_d     = ST_DONE;
                    cnt_d       = '0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    result_d    = w_final;
                    zero_d      = (w_final == '0);
                    carry_d     = w_arith & slice_cout;
                    ovf_d       = w_arith & (slice_cin_q ^ slice_cout);
                    slice_a_d   = 1'b0;
                    slice_b_d   = 1'b0;
                    slice_sub_d = 1'b0;
                    slice_cin_d = 1'b0;
                    slice_op_d  = 3'b000;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sh_q        <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            slice_a_q   <= 1'b0;
            slice_b_q   <= 1'b0;
            slice_sub_q <= 1'b0;
            slice_cin_q <= 1'b0;
            slice_op_q  <= 3'b000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sh_q        <= sh_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            slice_a_q   <= slice_a_d;
            slice_b_q   <= slice_b_d;
            slice_sub_q <= slice_sub_d;
            slice_cin_q <= slice_cin_d;
            slice_op_q  <= slice_op_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign slice_a   = slice_a_q;
    assign slice_b   = slice_b_q;
    assign slice_sub = slice_sub_q;
    assign slice_cin = slice_cin_q;
    assign slice_c1  = slice_op_q[2];
    assign slice_c2  = slice_op_q[1];
    assign slice_c3  = slice_op_q[0];

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_serial_ctrl
// Description : Self-checking bench for alu_serial_ctrl. A behavioural
//               one-bit slice closes the loop; expected words and flags come
//               from whole-word arithmetic in ref_alu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carry, ovf, zero;
    logic [W-1:0] result;
    logic         slice_a, slice_b, slice_sub, slice_cin;
    logic         slice_c1, slice_c2, slice_c3;
    logic         slice_out, slice_cout;

    int n_vec = 0;
    int n_err = 0;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .sub        (sub),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .carry      (carry),
        .ovf        (ovf),
        .zero       (zero),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_sub  (slice_sub),
        .slice_cin  (slice_cin),
        .slice_c1   (slice_c1),
        .slice_c2   (slice_c2),
        .slice_c3   (slice_c3),
        .slice_out  (slice_out),
        .slice_cout (slice_cout)
    );

    always #5 clk = ~clk;

    // Behavioural one-bit ALU slice.
    always_comb begin
        logic bb;
        bb         = slice_b ^ slice_sub;
        slice_out  = 1'b0;
        slice_cout = 1'b0;
        case ({slice_c1, slice_c2, slice_c3})
            3'b000: slice_out = ~(slice_a | slice_b);
            3'b001: slice_out = ~(slice_a & slice_b);
            3'b010: slice_out = slice_a | slice_b;
            3'b011: slice_out = slice_a & slice_b;
            3'b100: slice_out = slice_a ^ slice_b;
            3'b101: slice_out = ~(slice_a ^ slice_b);
            3'b110: begin
                slice_out  = slice_a ^ bb ^ slice_cin;
                slice_cout = (slice_a & bb) | (slice_a & slice_cin) | (bb & slice_cin);
            end
            default: slice_out = slice_a & slice_b;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns {zero, ovf, carry, result}.
    function automatic logic [W+2:0] ref_alu(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [2:0] o, input logic s);
        logic [W-1:0] r;
        logic [W:0]   t;
        logic         c, v;
        c = 1'b0;
        v = 1'b0;
        case (o)
            3'd0: r = ~(x | y);
            3'd1: r = ~(x & y);
            3'd2: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = ~(x ^ y);
            3'd6: begin
                if (s) begin
                    r = x - y;
                    c = (x >= y);
                    v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
                end else begin
                    t = {1'b0, x} + {1'b0, y};
                    r = t[W-1:0];
                    c = t[W];
                    v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
                end
            end
            default: r = x & y;
        endcase
        return {(r == '0), v, c, r};
    endfunction

    task automatic check_idle_slices(input string tag);
        check(tag, {slice_a, slice_b, slice_sub, slice_cin, slice_c1, slice_c2, slice_c3}, 0);
    endtask

    // Issues one operation from IDLE; returns at a negedge with the DUT idle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [2:0] top, input logic tsub, input string tag);
        int           lat, busy_n;
        bit           got;
        logic         dbusy;
        logic [W+2:0] exp;
        @(negedge clk);
        a = ta; b = tb_v; op = top; sub = tsub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); op = 3'($urandom); sub = 1'($urandom);
        lat = 1; busy_n = 0; got = 0; dbusy = 1'b0;
        while (!got && lat <= 40) begin
            if (lat == 1)
                check({tag, ".ctl"}, {slice_c1, slice_c2, slice_c3, slice_sub, slice_cin},
                      {top, tsub, tsub});
            if (busy) busy_n++;
            if (done) begin
                got = 1;
                dbusy = busy;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        exp = ref_alu(ta, tb_v, top, tsub);
        check({tag, ".lat"},    lat, W + 1);
        check({tag, ".busyn"},  busy_n, W);
        check({tag, ".ovlap"},  dbusy, 0);
        check({tag, ".res"},    result, exp[W-1:0]);
        check({tag, ".carry"},  carry, exp[W]);
        check({tag, ".ovf"},    ovf, exp[W+1]);
        check({tag, ".zero"},   zero, exp[W+2]);
        @(negedge clk);
        check({tag, ".pulse"},  {done, busy}, 0);
        check({tag, ".hold"},   result, exp[W-1:0]);
        check_idle_slices({tag, ".idle"});
    endtask

    logic [W-1:0] ha [0:63];
    logic [W-1:0] hb [0:63];

    initial begin
        logic [W+2:0] exp;
        logic [2:0]   rop;
        logic         rsub;
        int           ndone;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.status", {busy, done, carry, ovf, zero}, 0);
        check("rst.result", result, 0);
        check_idle_slices("rst.slices");
        rst = 1'b0;
        @(negedge clk);

        // Arithmetic directed cases
        run_op(16'h1234, 16'h0FFF, 3'b110, 1'b0, "add");
        run_op(16'hFFFF, 16'h0001, 3'b110, 1'b0, "wrap");
        run_op(16'h7FFF, 16'h0001, 3'b110, 1'b0, "ovf");
        run_op(16'h0005, 16'h0007, 3'b110, 1'b1, "sub_lt");
        run_op(16'h0007, 16'h0005, 3'b110, 1'b1, "sub_gt");
        run_op(16'h8000, 16'h0001, 3'b110, 1'b1, "sub_ovf");

        // Logic sweep
        for (int k = 0; k < 8; k++) begin
            if (k != 6) run_op(16'hFF00, 16'h0F0F, 3'(k), 1'b0, $sformatf("logic%0d", k));
        end

        // Randomized operations
        for (int k = 0; k < 40; k++) begin
            rop  = 3'($urandom);
            rsub = (rop == 3'b110) ? 1'($urandom) : 1'b0;
            run_op(W'($urandom), W'($urandom), rop, rsub, $sformatf("rnd%0d", k));
        end

        // Start held high with operands changing every cycle
        op = 3'b110; sub = 1'b0; start = 1'b1;
        for (int c = 0; c <= 53; c++) begin
            if (c > 0) begin
                check($sformatf("hs.done%0d", c), done, ((c % 18) == 17) ? 1 : 0);
                check("hs.ovlap", done & busy, 0);
                if (done) begin
                    exp = ref_alu(ha[c-17], hb[c-17], 3'b110, 1'b0);
                    check($sformatf("hs.res%0d", c), result, exp[W-1:0]);
                end
            end
            a = W'($urandom); b = W'($urandom);
            ha[c] = a; hb[c] = b;
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);

        // Reset in the middle of an ADD, during bit 7
        run_op(16'h4321, 16'h1111, 3'b110, 1'b0, "pre");
        @(negedge clk);
        a = 16'h1234; b = 16'h0FFF; op = 3'b110; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("mid.busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("mid.status", {busy, done, carry, ovf, zero}, 0);
        check("mid.result", result, 0);
        check_idle_slices("mid.slices");
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("mid.nodone", ndone, 0);
        run_op(16'h1234, 16'h0FFF, 3'b110, 1'b0, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
